// File: rtl/gpio_pkg.sv
// Shared register map and interrupt-type encoding for the GPIO block.
package gpio_pkg;

  localparam logic [7:0] OFF_OUT      = 8'h00;
  localparam logic [7:0] OFF_OE       = 8'h04;
  localparam logic [7:0] OFF_IN       = 8'h08;
  localparam logic [7:0] OFF_OUT_SET  = 8'h0C;
  localparam logic [7:0] OFF_OUT_CLR  = 8'h10;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h14;
  localparam logic [7:0] OFF_IRQ_TYPE = 8'h18;
  localparam logic [7:0] OFF_IRQ_POL  = 8'h1C;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h20;

  // Per-pin interrupt trigger type as stored in IRQ_TYPE.
  typedef enum logic {
    LEVEL = 1'b0,
    EDGE  = 1'b1
  } reg_type_e;

endpackage

// File: rtl/apb_if.sv
// APB3 bus bundle, 32-bit address and data.
interface apb_if;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave  (input  psel, penable, paddr, pwrite, pwdata,
                  output prdata, pready, pslverr);
  modport master (output psel, penable, paddr, pwrite, pwdata,
                  input  prdata, pready, pslverr);
endinterface

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous pin inputs.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] ff;

  // Shift the pin values through the flop chain.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ff <= '0;
    end else begin
      ff[0] <= din;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign dout = ff[STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// GPIO block with APB3 register access and per-pin edge/level interrupts.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  arstn,
  apb_if.slave                  apb_in,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_en,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] out_q, oe_q, en_q, type_q, pol_q, stat_q;
  logic [GPIO_WIDTH-1:0] sync, sync_prev;
  logic [GPIO_WIDTH-1:0] wdata, rsel, clr, set_cond, edge_hit, lvl_hit;
  logic [31:0]           rd32;
  logic [7:0]            addr;
  logic                  access, addr_ok, wr;
  logic                  unused_bits;

  gpio_sync #(.WIDTH(GPIO_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .arstn (arstn),
    .din   (gpio_in),
    .dout  (sync)
  );

  assign addr        = apb_in.paddr[7:0];
  assign wdata       = apb_in.pwdata[GPIO_WIDTH-1:0];
  assign access      = apb_in.psel & apb_in.penable;
  assign wr          = access & apb_in.pwrite & addr_ok;
  assign unused_bits = ^{apb_in.paddr[31:8], apb_in.pwdata};

  // Address decode and read mux; write-only and unmapped offsets read 0.
  always_comb begin
    addr_ok = 1'b1;
    rsel    = '0;
    case (addr)
      OFF_OUT:      rsel = out_q;
      OFF_OE:       rsel = oe_q;
      OFF_IN:       rsel = sync;
      OFF_OUT_SET,
      OFF_OUT_CLR:  rsel = '0;
      OFF_IRQ_EN:   rsel = en_q;
      OFF_IRQ_TYPE: rsel = type_q;
      OFF_IRQ_POL:  rsel = pol_q;
      OFF_IRQ_STAT: rsel = stat_q;
      default:      addr_ok = 1'b0;
    endcase
    rd32                 = '0;
    rd32[GPIO_WIDTH-1:0] = rsel;
  end

  // Zero-wait-state response; reset forces a quiet bus.
  assign apb_in.pready  = access;
  assign apb_in.prdata  = (arstn && access) ? rd32 : '0;
  assign apb_in.pslverr = arstn & access & ~addr_ok;

  // Output and configuration registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      out_q  <= '0;
      oe_q   <= '0;
      en_q   <= '0;
      type_q <= '0;
      pol_q  <= '0;
    end else if (wr) begin
      case (addr)
        OFF_OUT:      out_q  <= wdata;
        OFF_OUT_SET:  out_q  <= out_q | wdata;
        OFF_OUT_CLR:  out_q  <= out_q & ~wdata;
        OFF_OE:       oe_q   <= wdata;
        OFF_IRQ_EN:   en_q   <= wdata;
        OFF_IRQ_TYPE: type_q <= wdata;
        OFF_IRQ_POL:  pol_q  <= wdata;
        default: ;
      endcase
    end
  end

  assign edge_hit = (pol_q & sync & ~sync_prev) | (~pol_q & ~sync & sync_prev);
  assign lvl_hit  = ~(sync ^ pol_q);
  assign clr      = (wr && addr == OFF_IRQ_STAT) ? wdata : '0;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_cond
    assign set_cond[i] = en_q[i] &
      ((reg_type_e'(type_q[i]) == EDGE) ? edge_hit[i] : lvl_hit[i]);
  end

  // Delayed sync copy for edges; status bits are W1C with set priority.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync_prev <= '0;
      stat_q    <= '0;
    end else begin
      sync_prev <= sync;
      stat_q    <= (stat_q & ~clr) | set_cond;
    end
  end

  assign gpio_out = out_q;
  assign gpio_en  = oe_q;
  assign irq      = |(stat_q & en_q);

endmodule

// File: tb/tb_gpio_irq.sv
// Directed self-checking bench for gpio_irq (GPIO_WIDTH=32, SYNC_STAGES=2).
module tb_gpio_irq;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out, gpio_en;
  logic        irq;
  logic [31:0] rd;
  logic        err;
  int          n_chk = 0;
  int          n_fail = 0;

  apb_if apb();

  gpio_irq #(.GPIO_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .arstn    (arstn),
    .apb_in   (apb),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_en  (gpio_en),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, input bit chk_rdy = 0);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = {24'h0, a}; apb.pwdata = d;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    if (chk_rdy) check("pready_wr", {31'h0, apb.pready}, 32'h1);
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = {24'h0, a};
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    d = apb.prdata; e = apb.pslverr;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  initial begin
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = '0; apb.pwdata = '0;

    // Reset state, with a bogus access phase held on the bus.
    apb.psel = 1; apb.penable = 1; apb.paddr = 32'h24;
    #12;
    check("rst_out",     gpio_out, 32'h0);
    check("rst_en",      gpio_en,  32'h0);
    check("rst_irq",     {31'h0, irq}, 32'h0);
    check("rst_pslverr", {31'h0, apb.pslverr}, 32'h0);
    check("rst_prdata",  apb.prdata, 32'h0);
    apb.psel = 0; apb.penable = 0; apb.paddr = '0;
    @(negedge clk); arstn = 1'b1;

    // Plain OUT / OE writes.
    apb_wr(OFF_OUT, 32'hFFFF_FFFF, 1);
    apb_wr(OFF_OE,  32'h0000_FFFF, 1);
    check("gpio_out_ff", gpio_out, 32'hFFFF_FFFF);
    check("gpio_en_ffff", gpio_en, 32'h0000_FFFF);
    apb_rd(OFF_OE, rd, err);
    check("oe_rd", rd, 32'h0000_FFFF);

    // Set/clear aliases.
    apb_wr(OFF_OUT, 32'h0F);
    apb_wr(OFF_OUT_SET, 32'hF0);
    apb_wr(OFF_OUT_CLR, 32'h03);
    check("out_setclr", gpio_out, 32'hFC);
    apb_rd(OFF_OUT_SET, rd, err);
    check("set_rd0", rd, 32'h0);
    check("set_rd_err", {31'h0, err}, 32'h0);

    // Input synchroniser readback.
    gpio_in = 32'hA5A5_0000;
    repeat (3) @(posedge clk);
    apb_rd(OFF_IN, rd, err);
    check("in_rd", rd, 32'hA5A5_0000);
    gpio_in = '0;
    repeat (3) @(posedge clk);

    // Rising-edge interrupt on pin 0 and its latency.
    apb_wr(OFF_IRQ_TYPE, 32'h1);
    apb_wr(OFF_IRQ_POL,  32'h1);
    apb_wr(OFF_IRQ_EN,   32'h1);
    @(negedge clk); gpio_in[0] = 1'b1;
    @(posedge clk); #1; check("lat_e1", {31'h0, irq}, 32'h0);
    @(posedge clk); #1; check("lat_e2", {31'h0, irq}, 32'h0);
    apb_rd(OFF_IN, rd, err);
    check("in_bit0", rd, 32'h1);
    check("lat_e3", {31'h0, irq}, 32'h1);
    apb_wr(OFF_IRQ_STAT, 32'h1);
    check("w1c_irq", {31'h0, irq}, 32'h0);
    apb_rd(OFF_IRQ_STAT, rd, err);
    check("w1c_stat", rd, 32'h0);

    // Level-high interrupt on pin 3 keeps re-asserting while the pin is high.
    apb_wr(OFF_IRQ_TYPE, 32'h1);
    apb_wr(OFF_IRQ_POL,  32'h9);
    gpio_in[3] = 1'b1;
    repeat (3) @(posedge clk);
    apb_wr(OFF_IRQ_EN, 32'h9);
    @(posedge clk); #1;
    apb_wr(OFF_IRQ_STAT, 32'h8);
    @(posedge clk); #1;
    apb_rd(OFF_IRQ_STAT, rd, err);
    check("lvl_reset", rd, 32'h8);
    check("lvl_irq", {31'h0, irq}, 32'h1);
    @(negedge clk); gpio_in[3] = 1'b0;
    repeat (3) @(posedge clk);
    apb_wr(OFF_IRQ_STAT, 32'h8);
    check("lvl_clr_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("lvl_stay0", {31'h0, irq}, 32'h0);

    // Rising edge lands on the same edge as a W1C of that bit: set wins.
    apb_wr(OFF_IRQ_EN, 32'h1);
    @(negedge clk); gpio_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    apb_rd(OFF_IRQ_STAT, rd, err);
    check("pre_coinc", rd, 32'h0);
    @(negedge clk); gpio_in[0] = 1'b1;            // before edge k
    @(negedge clk);                               // setup phase over edge k+1
    apb.psel = 1; apb.penable = 0; apb.pwrite = 1;
    apb.paddr = {24'h0, OFF_IRQ_STAT}; apb.pwdata = 32'h1;
    @(negedge clk); apb.penable = 1;              // commit at edge k+2
    @(posedge clk); #1;
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
    apb_rd(OFF_IRQ_STAT, rd, err);
    check("coinc_stat", rd, 32'h1);

    // Disabling the pin masks irq but keeps status.
    apb_wr(OFF_IRQ_EN, 32'h0);
    check("mask_irq", {31'h0, irq}, 32'h0);
    apb_rd(OFF_IRQ_STAT, rd, err);
    check("mask_stat", rd, 32'h1);
    apb_wr(OFF_IRQ_STAT, 32'h1);

    // Unmapped address.
    apb_rd(8'h24, rd, err);
    check("bad_err", {31'h0, err}, 32'h1);
    check("bad_data", rd, 32'h0);

    // Reset pulsed in the middle of an OUT write.
    @(negedge clk);
    apb.psel = 1; apb.penable = 0; apb.pwrite = 1;
    apb.paddr = {24'h0, OFF_OUT}; apb.pwdata = 32'h1234_5678;
    @(negedge clk); apb.penable = 1;
    #2 arstn = 1'b0;
    @(posedge clk); #1;
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
    check("mid_rst_out", gpio_out, 32'h0);
    check("mid_rst_en",  gpio_en,  32'h0);
    @(negedge clk); arstn = 1'b1;
    apb_rd(OFF_OUT, rd, err);      check("post_out",  rd, 32'h0);
    apb_rd(OFF_IRQ_TYPE, rd, err); check("post_type", rd, 32'h0);
    apb_rd(OFF_IRQ_POL, rd, err);  check("post_pol",  rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 32, number of GPIO pins (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, depth of the input synchroniser (>=2).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port apb_in  apb_if slave  32-bit addr/data  APB3 register access (PSEL, PENABLE, PADDR, PWRITE, PWDATA, PRDATA, PREADY, PSLVERR).
REQ-006 SHALL have port gpio_in  input  GPIO_WIDTH  asynchronous pin inputs.
REQ-007 SHALL have port gpio_out  output  GPIO_WIDTH  pin output values.
REQ-008 SHALL have port gpio_en  output  GPIO_WIDTH  per-pin output enable, 1 = drive.
REQ-009 SHALL have port irq  output  1  interrupt, active-high level.

Function
REQ-010 SHALL decode PADDR[7:0] as the register map: 0x00 OUT rw; 0x04 OE rw; 0x08 IN ro; 0x0C OUT_SET wo; 0x10 OUT_CLR wo; 0x14 IRQ_EN rw; 0x18 IRQ_TYPE rw (1 = edge, 0 = level); 0x1C IRQ_POL rw (1 = high/rising, 0 = low/falling); 0x20 IRQ_STAT rw1c.
REQ-011 SHALL assert PREADY in every access phase (PSEL&PENABLE), with zero wait states and PRDATA valid in the same cycle.
REQ-012 SHALL commit writes at the clock edge that ends the access phase; setup-phase cycles have no effect.
REQ-013 SHALL, for an address not in the map, assert PSLVERR with PREADY, ignore writes and return 0 on reads.
REQ-014 SHALL ignore register bits at and above GPIO_WIDTH on write and read them as 0.
REQ-015 SHALL read OUT_SET and OUT_CLR as 0.
REQ-016 SHALL, on an OUT_SET write, apply OUT |= PWDATA; on an OUT_CLR write, apply OUT &= ~PWDATA.
REQ-017 SHALL drive gpio_out = OUT and gpio_en = OE directly from registers, with no pin masking by OE.
REQ-018 SHALL pass gpio_in through SYNC_STAGES flops; IN returns the synchroniser output.
REQ-019 SHALL keep sync_prev, a one-flop delayed copy of the synchroniser output, for edge detection.
REQ-020 SHALL set IRQ_STAT[i] at a clock edge only when IRQ_EN[i]=1 and the bit's condition holds:
- edge mode: rising (POL=1) or falling (POL=0) between sync_prev and sync;
- level mode: sync equals POL.
REQ-021 SHALL clear IRQ_STAT[i] on a write of 1 to that bit; if a set condition and a clear occur in the same cycle, the set wins.
REQ-022 SHALL re-set a level-mode status bit on the edge after it is cleared if the level is still active.
REQ-023 SHALL leave IRQ_STAT unchanged when IRQ_EN is cleared; irq is then masked.
REQ-024 SHALL drive irq = |(IRQ_STAT & IRQ_EN) combinationally from registers.
REQ-025 SHALL meet this latency: gpio_in stable before edge k -> IN updated after edge k+SYNC_STAGES-1 -> edge-mode IRQ_STAT and irq high after edge k+SYNC_STAGES.

Reset
REQ-026 SHALL, while arstn=0, asynchronously clear OUT, OE, IRQ_EN, IRQ_TYPE, IRQ_POL, IRQ_STAT, all synchroniser flops and sync_prev.
REQ-027 SHALL hold gpio_out=0, gpio_en=0, irq=0, PSLVERR=0 and PRDATA=0 during reset.
REQ-028 SHALL abandon any APB transfer in flight when reset is asserted; no register write occurs.

Structure
REQ-029 SHALL place register offsets and the reg_type_e (LEVEL/EDGE) enum in shared package gpio_pkg.
REQ-030 SHALL implement the synchroniser as sub-module gpio_sync, parametrised by width and stage count, with async active-low reset.

Verification
REQ-031 SHALL cover: write OUT=0xFFFF_FFFF, OE=0x0000_FFFF -> gpio_out=0xFFFF_FFFF, gpio_en=0x0000_FFFF, PREADY=1 in each access phase.
REQ-032 SHALL cover: OUT=0x0F, OUT_SET 0xF0, OUT_CLR 0x03 -> gpio_out=0xFC, OUT_SET readback 0.
REQ-033 SHALL cover: IRQ_EN=1, TYPE=1, POL=1, gpio_in[0] 0->1 -> irq high exactly 2 edges later (SYNC_STAGES=2); W1C 0x1 -> irq low next cycle.
REQ-034 SHALL cover: level-high mode, gpio_in[3] held 1, W1C 0x8 -> IRQ_STAT[3] re-sets next edge; gpio_in[3]=0 then W1C -> irq stays 0.
REQ-035 SHALL cover: rising edge coincident with a W1C of the same bit -> IRQ_STAT stays 1.
REQ-036 SHALL cover: read 0x24 -> PSLVERR=1, PRDATA=0; arstn pulsed mid-transfer -> all registers 0, write not committed.
